// File: rtl/multi_key_ctrl_if.sv
// multi_key_ctrl_if: raw key inputs and per-channel gesture pulses.
// master drives the raw keys, slave is the key controller.
interface multi_key_ctrl_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_short;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_double;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_level,
        input  key_short,
        input  key_long,
        input  key_double,
        input  key_repeat
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_short,
        output key_long,
        output key_double,
        output key_repeat
    );
endinterface

// File: rtl/multi_key_ctrl.sv
// multi_key_ctrl: N-channel key front end (sync, debounce, gesture FSM).
// Optional macro KEY_REPEAT_EN adds hold auto-repeat pulses on key_repeat.
module multi_key_ctrl #(
    parameter int N_KEYS      = 4,
    parameter int CLK_FREQ    = 27_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 1000,
    parameter int DCLICK_MS   = 300,
    parameter int REPEAT_MS   = 200,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic clk,
    input logic rst,
    multi_key_ctrl_if.slave bus
);
    localparam int CYC_MS   = CLK_FREQ / 1000;
    localparam int CNT_DB   = CYC_MS * DEBOUNCE_MS;
    localparam int CNT_HOLD = CYC_MS * HOLD_MS;
    localparam int CNT_DC   = CYC_MS * DCLICK_MS;
    localparam int CNT_REP  = CYC_MS * REPEAT_MS;
    localparam int MAX_A    = (CNT_DB > CNT_HOLD) ? CNT_DB : CNT_HOLD;
    localparam int MAX_B    = (CNT_DC > CNT_REP) ? CNT_DC : CNT_REP;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW       = $clog2(MAX_C) + 1;

    localparam logic [TW-1:0] DB_LAST   = TW'((CNT_DB > 0) ? CNT_DB - 1 : 0);
    localparam logic [TW-1:0] HOLD_LAST = TW'((CNT_HOLD > 0) ? CNT_HOLD - 1 : 0);
    localparam logic [TW-1:0] DC_LAST   = TW'((CNT_DC > 0) ? CNT_DC - 1 : 0);
`ifdef KEY_REPEAT_EN
    localparam logic [TW-1:0] REP_LAST  = TW'((CNT_REP > 0) ? CNT_REP - 1 : 0);
`endif
    localparam bit   NO_DC    = (CNT_DC == 0);
    localparam logic RELEASED = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        LONG,
        WAIT2,
        PRESS2
    } state_t;

    logic [N_KEYS-1:0] sync1, sync2, pressed;
    logic [N_KEYS-1:0] level_q, short_q, long_q, double_q;
`ifdef KEY_REPEAT_EN
    logic [N_KEYS-1:0] rep_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= {N_KEYS{RELEASED}};
            sync2 <= {N_KEYS{RELEASED}};
        end else begin
            sync1 <= bus.key_in;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state;
        logic [TW-1:0] db_cnt, timer, timer_inc;
        logic          lvl, lvl_d, flip;
        logic          p_short, p_long, p_double;
`ifdef KEY_REPEAT_EN
        logic          p_rep;
`endif

        // FSM reacts to the debouncer's next value so gesture pulses
        // line up with the key_level edge that caused them.
        assign flip      = (pressed[i] != lvl) && (db_cnt >= DB_LAST);
        assign lvl_d     = flip ? pressed[i] : lvl;
        assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt <= '0;
                lvl    <= 1'b0;
            end else if (flip || pressed[i] == lvl) begin
                db_cnt <= '0;
                lvl    <= lvl_d;
            end else begin
                db_cnt <= db_cnt + TW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= IDLE;
                timer    <= '0;
                p_short  <= 1'b0;
                p_long   <= 1'b0;
                p_double <= 1'b0;
`ifdef KEY_REPEAT_EN
                p_rep    <= 1'b0;
`endif
            end else begin
                p_short  <= 1'b0;
                p_long   <= 1'b0;
                p_double <= 1'b0;
`ifdef KEY_REPEAT_EN
                p_rep    <= 1'b0;
`endif
                unique case (state)
                    IDLE: begin
                        if (lvl_d) begin
                            state <= PRESS;
                            timer <= '0;
                        end
                    end
                    PRESS: begin
                        if (!lvl_d) begin
                            state <= WAIT2;
                            timer <= '0;
                        end else if (timer == HOLD_LAST) begin
                            p_long <= 1'b1;
                            state  <= LONG;
                            timer  <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    LONG: begin
                        if (!lvl_d) begin
                            state <= IDLE;
                            timer <= '0;
`ifdef KEY_REPEAT_EN
                        end else if (timer == REP_LAST) begin
                            p_rep <= 1'b1;
                            timer <= '0;
                        end else begin
                            timer <= timer_inc;
`endif
                        end
                    end
                    WAIT2: begin
                        timer <= '0;
                        if (NO_DC) begin
                            p_short <= 1'b1;
                            state   <= lvl_d ? PRESS : IDLE;
                        end else if (lvl_d) begin
                            p_double <= 1'b1;
                            state    <= PRESS2;
                        end else if (timer == DC_LAST) begin
                            p_short <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    PRESS2: begin
                        if (!lvl_d) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end

        assign level_q[i]  = lvl;
        assign short_q[i]  = p_short;
        assign long_q[i]   = p_long;
        assign double_q[i] = p_double;
`ifdef KEY_REPEAT_EN
        assign rep_q[i]    = p_rep;
`endif
    end

    assign bus.key_level  = level_q;
    assign bus.key_short  = short_q;
    assign bus.key_long   = long_q;
    assign bus.key_double = double_q;
`ifdef KEY_REPEAT_EN
    assign bus.key_repeat = rep_q;
`else
    assign bus.key_repeat = '0;
`endif
endmodule

// File: tb/tb_multi_key_ctrl.sv
// tb_multi_key_ctrl: directed gesture scenarios for multi_key_ctrl.
// Expected cycle offsets are hand-derived for the reduced test timing.
module tb_multi_key_ctrl;
    localparam int N = 4;

    localparam int K_LR = 0;
    localparam int K_LF = 1;
    localparam int K_SH = 2;
    localparam int K_LG = 3;
    localparam int K_DB = 4;
    localparam int K_RP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t0;

    multi_key_ctrl_if #(.N_KEYS(N)) bus ();

    multi_key_ctrl #(
        .N_KEYS      (N),
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (2),
        .HOLD_MS     (10),
        .DCLICK_MS   (5),
        .REPEAT_MS   (3),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int ch;
        int kind;
    } ev_t;

    ev_t      evq[$];
    logic [N-1:0] lvl_prev = '0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.key_level[i] != lvl_prev[i])
                evq.push_back('{cyc, i, bus.key_level[i] ? K_LR : K_LF});
            if (bus.key_short[i])  evq.push_back('{cyc, i, K_SH});
            if (bus.key_long[i])   evq.push_back('{cyc, i, K_LG});
            if (bus.key_double[i]) evq.push_back('{cyc, i, K_DB});
            if (bus.key_repeat[i]) evq.push_back('{cyc, i, K_RP});
        end
        lvl_prev = bus.key_level;
    end

    function automatic int n_ev(int ch, int kind);
        int n = 0;
        foreach (evq[k])
            if (evq[k].ch == ch && evq[k].kind == kind) n++;
        return n;
    endfunction

    function automatic int t_ev(int ch, int kind, int nth);
        int n = 0;
        int r = -1000;
        foreach (evq[k]) begin
            if (evq[k].ch == ch && evq[k].kind == kind) begin
                if (n == nth) r = evq[k].t;
                n++;
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.key_in = '1;
        rst = 1'b1;
        tick(3);
        chk("rst_outs", 32'({bus.key_level, bus.key_short, bus.key_long,
                             bus.key_double, bus.key_repeat}), 0);
        rst = 1'b0;
        tick(5);

        // short press on key 0
        evq.delete();
        t0 = cyc;
        bus.key_in[0] = 1'b0;
        tick(6);
        bus.key_in[0] = 1'b1;
        tick(30);
        chk("s1_rise",   t_ev(0, K_LR, 0) - t0, 4);
        chk("s1_fall",   t_ev(0, K_LF, 0) - t0, 10);
        chk("s1_sh_dly", t_ev(0, K_SH, 0) - t_ev(0, K_LF, 0), 5);
        chk("s1_n_sh",   n_ev(0, K_SH), 1);
        chk("s1_n_ev",   evq.size(), 3);

        // glitches on key 1
        evq.delete();
        bus.key_in[1] = 1'b0;
        tick(1);
        bus.key_in[1] = 1'b1;
        tick(10);
        bus.key_in[1] = 1'b0;
        tick(1);
        bus.key_in[1] = 1'b1;
        tick(1);
        bus.key_in[1] = 1'b0;
        tick(1);
        bus.key_in[1] = 1'b1;
        tick(15);
        chk("s2_n_rise", n_ev(1, K_LR), 0);
        chk("s2_n_ev",   evq.size(), 0);
        chk("s2_level",  32'(bus.key_level), 0);

        // long hold and repeat on key 2
        evq.delete();
        t0 = cyc;
        bus.key_in[2] = 1'b0;
        tick(25);
        bus.key_in[2] = 1'b1;
        tick(20);
        chk("s3_rise",   t_ev(2, K_LR, 0) - t0, 4);
        chk("s3_lg_dly", t_ev(2, K_LG, 0) - t_ev(2, K_LR, 0), 10);
        chk("s3_n_lg",   n_ev(2, K_LG), 1);
        chk("s3_n_sh",   n_ev(2, K_SH), 0);
        chk("s3_n_db",   n_ev(2, K_DB), 0);
        chk("s3_fall",   t_ev(2, K_LF, 0) - t0, 29);
`ifdef KEY_REPEAT_EN
        chk("s3_n_rp",   n_ev(2, K_RP), 4);
        chk("s3_rp1",    t_ev(2, K_RP, 0) - t_ev(2, K_LG, 0), 3);
        chk("s3_rp_gap", t_ev(2, K_RP, 3) - t_ev(2, K_RP, 2), 3);
`else
        chk("s3_n_rp",   n_ev(2, K_RP), 0);
`endif

        // double click on key 3
        evq.delete();
        t0 = cyc;
        bus.key_in[3] = 1'b0;
        tick(4);
        bus.key_in[3] = 1'b1;
        tick(3);
        bus.key_in[3] = 1'b0;
        tick(4);
        bus.key_in[3] = 1'b1;
        tick(20);
        chk("s4_rise2",  t_ev(3, K_LR, 1) - t0, 11);
        chk("s4_db_t",   t_ev(3, K_DB, 0), t_ev(3, K_LR, 1));
        chk("s4_n_db",   n_ev(3, K_DB), 1);
        chk("s4_n_sh",   n_ev(3, K_SH), 0);
        chk("s4_n_lg",   n_ev(3, K_LG), 0);

        // concurrent keys with reset mid-hold
        evq.delete();
        t0 = cyc;
        bus.key_in[1] = 1'b0;
        tick(2);
        bus.key_in[0] = 1'b0;
        tick(6);
        bus.key_in[0] = 1'b1;
        tick(5);
        chk("s5_lvl_pre", 32'(bus.key_level[1]), 1);
        rst = 1'b1;
        tick(1);
        chk("s5_rst_outs", 32'({bus.key_level, bus.key_short, bus.key_long,
                                bus.key_double, bus.key_repeat}), 0);
        rst = 1'b0;
        tick(20);
        bus.key_in[1] = 1'b1;
        tick(20);
        chk("s5_k1_fall", t_ev(1, K_LF, 0) - t0, 14);
        chk("s5_rerise",  t_ev(1, K_LR, 1) - t0, 18);
        chk("s5_lg_dly",  t_ev(1, K_LG, 0) - t_ev(1, K_LR, 1), 10);
        chk("s5_n_lg",    n_ev(1, K_LG), 1);
        chk("s5_k0_sh",   n_ev(0, K_SH), 0);
        chk("s5_k1_sh",   n_ev(1, K_SH), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
